// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the binary GCD engine
//   state_t         FSM states of gcd_binary_engine
//   GCD_WIDTH       operand/result width
//   GCD_MAX_LATENCY worst-case cycles from start edge to done
//   GCD_CNT_W       width of the optional busy-cycle counter
package gcd_pkg;
    localparam int GCD_WIDTH       = 32;
    localparam int GCD_MAX_LATENCY = 100;
    localparam int GCD_CNT_W       = 16;
    typedef enum logic [2:0] {IDLE, STRIP, REDUCE, FINISH, DONE} state_t;
endpackage

// File: rtl/gcd_reduce_step.sv
// gcd_reduce_step: next (x, y) for one binary-GCD reduce iteration
//   x, y   in  current working values
//   nx, ny out values after one step (only meaningful when eq=0)
//   eq     out x == y, reduction finished
module gcd_reduce_step import gcd_pkg::*; #(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] nx,
    output logic [WIDTH-1:0] ny,
    output logic             eq
);
    logic gt;
    assign eq = x == y;
    assign gt = x > y;
    // Priority: halve an even value first; with both odd, the difference is even
    // so it can be halved in the same step. Only larger-minus-smaller is taken.
    assign nx = !x[0] ? x >> 1 : (!y[0] ? x : (gt ? (x - y) >> 1 : x));
    assign ny = !x[0] ? y : (!y[0] ? y >> 1 : (gt ? y : (y - x) >> 1));
endmodule

// File: rtl/gcd_binary_engine.sv
// gcd_binary_engine: iterative Stein GCD of two unsigned operands
//   clk, rst  clock, asynchronous active-high reset
//   start     single-cycle launch, ignored while busy
//   a, b      operands, sampled on an accepted start
//   result    gcd(a, b), valid while done=1
//   done      high from completion until next accepted start
//   busy      high in STRIP, REDUCE, FINISH
//   cycles    busy-cycle count of last/current run (GCD_CYCLE_COUNT_EN only)
module gcd_binary_engine import gcd_pkg::*; #(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
    ,
    output logic [GCD_CNT_W-1:0] cycles
`endif
);
    state_t st, nst;
    logic [WIDTH-1:0] x, y, rx, ry;
    logic [5:0] k;
    logic eq, any_zero, accept;

    gcd_reduce_step #(.WIDTH(WIDTH)) u_step (.x(x), .y(y), .nx(rx), .ny(ry), .eq(eq));

    assign any_zero = x == '0 || y == '0;
    assign busy     = st == STRIP || st == REDUCE || st == FINISH;
    assign accept   = start && (st == IDLE || st == DONE);

    always_ff @(posedge clk or posedge rst)
        if (rst) st <= IDLE;
        else     st <= nst;

    always_comb begin
        nst = st;
        case (st)
            IDLE, DONE: nst = start ? STRIP : st;
            STRIP:      nst = any_zero ? FINISH : ((x[0] || y[0]) ? REDUCE : STRIP);
            REDUCE:     nst = eq ? FINISH : REDUCE;
            FINISH:     nst = DONE;
            default:    nst = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            k      <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            case (st)
                IDLE, DONE: if (accept) begin
                    x    <= a;
                    y    <= b;
                    k    <= '0;
                    done <= 1'b0;
                end
                STRIP: if (any_zero) x <= x | y;
                else if (!x[0] && !y[0]) begin
                    x <= x >> 1;
                    y <= y >> 1;
                    k <= k + 6'd1;
                end
                REDUCE: if (!eq) begin
                    x <= rx;
                    y <= ry;
                end
                FINISH: begin
                    result <= x << k;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef GCD_CYCLE_COUNT_EN
    // Saturating count of busy cycles, cleared on each accepted start.
    always_ff @(posedge clk or posedge rst)
        if (rst)                       cycles <= '0;
        else if (accept)               cycles <= '0;
        else if (busy && ~&cycles)     cycles <= cycles + 1'b1;
`endif
endmodule

// File: tb/tb_gcd_binary_engine.sv
// tb_gcd_binary_engine: scoreboard bench for gcd_binary_engine
module tb_gcd_binary_engine;
    import gcd_pkg::*;

    logic        clk = 0, rst = 1, start = 0;
    logic [31:0] a = 0, b = 0, result;
    logic        done, busy;
`ifdef GCD_CYCLE_COUNT_EN
    logic [15:0] cycles;
`endif
    int cmp = 0, bad = 0;
    logic [31:0] sb[$];

    gcd_binary_engine dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .result(result), .done(done), .busy(busy)
`ifdef GCD_CYCLE_COUNT_EN
        , .cycles(cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [31:0] ia, input logic [31:0] ib, input bit push, input logic [31:0] exp);
        @(negedge clk);
        a = ia; b = ib; start = 1;
        if (push) sb.push_back(exp);
        @(posedge clk); #1;
        start = 0;
    endtask

    // n counts edges from the start-sampling edge inclusive; bc counts busy samples.
    task automatic wait_done(output int n, output int bc);
        n = 1;
        bc = busy ? 1 : 0;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        cmp++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got %0d want 0", result); end
        cmp++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef GCD_CYCLE_COUNT_EN
        cmp++; if (cycles !== 16'd0) begin bad++; $display("FAIL reset_cycles got %0d want 0", cycles); end
`endif
        @(negedge clk) rst = 0;
    endtask

    task automatic test_basic;
        logic [31:0] ta[3] = '{32'd48, 32'd1024, 32'hFFFFFFFF};
        logic [31:0] tb[3] = '{32'd18, 32'd4096, 32'd1};
        logic [31:0] te[3] = '{32'd6,  32'd1024, 32'd1};
        int n, bc;
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            launch(ta[i], tb[i], 1, te[i]);
            cmp++; if (busy !== 1'b1) begin bad++; $display("FAIL basic%0d_busy_rise got %b want 1", i, busy); end
            wait_done(n, bc);
            exp = sb.pop_front();
            cmp++; if (n > GCD_MAX_LATENCY) begin bad++; $display("FAIL basic%0d_latency got %0d want <=%0d", i, n, GCD_MAX_LATENCY); end
            cmp++; if (result !== exp) begin bad++; $display("FAIL basic%0d_result got %0d want %0d", i, result, exp); end
            cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL basic%0d_busy_fall got %b want 0", i, busy); end
        end
    endtask

    task automatic test_zero;
        logic [31:0] ta[3] = '{32'd0, 32'd0, 32'd9};
        logic [31:0] tb[3] = '{32'd0, 32'd7, 32'd0};
        logic [31:0] te[3] = '{32'd0, 32'd7, 32'd9};
        int n, bc;
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            launch(ta[i], tb[i], 1, te[i]);
            wait_done(n, bc);
            exp = sb.pop_front();
            cmp++; if (n !== 3) begin bad++; $display("FAIL zero%0d_latency got %0d want 3", i, n); end
            cmp++; if (result !== exp) begin bad++; $display("FAIL zero%0d_result got %0d want %0d", i, result, exp); end
        end
    endtask

    task automatic test_busy_start;
        int n, bc;
        logic [31:0] exp;
        launch(32'd48, 32'd18, 1, 32'd6);
        @(posedge clk); #1;
        launch(32'd5, 32'd7, 0, 32'd0);
        wait_done(n, bc);
        exp = sb.pop_front();
        cmp++; if (result !== exp) begin bad++; $display("FAIL busy_start_result got %0d want %0d", result, exp); end
        repeat (3) @(posedge clk);
        #1;
        cmp++; if (done !== 1'b1 || result !== exp) begin bad++; $display("FAIL busy_start_hold got done=%b res=%0d want 1/%0d", done, result, exp); end
    endtask

    task automatic test_reset_midrun;
        int n, bc;
        logic [31:0] exp;
        launch(32'd100, 32'd75, 0, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1;
        #1;
        cmp++; if (result !== 32'd0 || done !== 1'b0 || busy !== 1'b0)
            begin bad++; $display("FAIL midrun_reset got res=%0d done=%b busy=%b want 0/0/0", result, done, busy); end
        @(negedge clk) rst = 0;
        launch(32'd100, 32'd75, 1, 32'd25);
        wait_done(n, bc);
        exp = sb.pop_front();
        cmp++; if (result !== exp) begin bad++; $display("FAIL midrun_rerun_result got %0d want %0d", result, exp); end
    endtask

    task automatic test_restart;
        int n, bc;
        logic [31:0] exp;
        bit held;
        launch(32'd48, 32'd18, 1, 32'd6);
        wait_done(n, bc);
        exp = sb.pop_front();
        cmp++; if (result !== exp) begin bad++; $display("FAIL restart_first_result got %0d want %0d", result, exp); end
`ifdef GCD_CYCLE_COUNT_EN
        cmp++; if (cycles !== 16'(bc)) begin bad++; $display("FAIL restart_first_cycles got %0d want %0d", cycles, bc); end
`endif
        launch(32'd35, 32'd21, 1, 32'd7);
        cmp++; if (done !== 1'b0) begin bad++; $display("FAIL restart_done_drop got %b want 0", done); end
`ifdef GCD_CYCLE_COUNT_EN
        cmp++; if (cycles !== 16'd0) begin bad++; $display("FAIL restart_cycles_clear got %0d want 0", cycles); end
`endif
        held = 1;
        n = 1;
        while (!done && n < 400) begin
            if (result !== 32'd6) held = 0;
            @(posedge clk); #1;
            n++;
        end
        cmp++; if (!held) begin bad++; $display("FAIL restart_old_result_held got 0 want 1"); end
        cmp++; if (n > GCD_MAX_LATENCY) begin bad++; $display("FAIL restart_latency got %0d want <=%0d", n, GCD_MAX_LATENCY); end
        exp = sb.pop_front();
        cmp++; if (result !== exp) begin bad++; $display("FAIL restart_second_result got %0d want %0d", result, exp); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_busy_start;
        test_reset_midrun;
        test_restart;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
